// File: rtl/div_arb_pkg.sv
// Shared widths and FSM state encoding for the divider-sharing arbiter.
package div_arb_pkg;

  localparam int W_W = 10;
  localparam int D_W = 5;
  localparam int Q_W = 5;
  localparam int R_W = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/div_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr, wrapping.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   idx,
  output logic            any_req
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Scan from the far end down so the nearest requester to rr_ptr is written last.
  always_comb begin
    idx     = '0;
    any_req = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap_add(rr_ptr, k)]) begin
        idx     = wrap_add(rr_ptr, k);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one restoring divider among NREQ requesters: round-robin grant, start/done
// handshake with rising-edge completion detect, and a hung-divider timeout.
module div_share_arbiter
  import div_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*10-1:0] req_w,
  input  logic [NREQ*5-1:0] req_d,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [Q_W-1:0]    rsp_quo,
  output logic [R_W-1:0]    rsp_rem,
  output logic              rsp_ov,
  output logic              rsp_dbz,
  output logic              rsp_tmo,
  output logic              busy,
  output logic [W_W-1:0]    div_w,
  output logic [D_W-1:0]    div_d,
  output logic              div_start,
  input  logic              div_done,
  input  logic [Q_W-1:0]    div_quo,
  input  logic [R_W-1:0]    div_rem,
  input  logic              div_ov,
  input  logic              div_dbz
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   pick_idx;
  logic            any_req;
  logic [TW-1:0]   tmo_cnt;
  logic            done_q;
  logic            done_rise;
  logic            tmo_hit;
  logic [W_W-1:0]  w_arr [NREQ];
  logic [D_W-1:0]  d_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_arr[i] = req_w[W_W*i +: W_W];
      d_arr[i] = req_d[D_W*i +: D_W];
    end
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  // A done level left high by the previous op never looks like a fresh edge.
  assign done_rise = div_done & ~done_q;
  assign tmo_hit   = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    rsp_valid = '0;
    div_start = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (any_req) state_nxt = S_START;
      end
      S_START: begin
        gnt[idx]  = 1'b1;
        div_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        gnt[idx] = 1'b1;
        if (done_rise || tmo_hit) state_nxt = S_RESP;
      end
      S_RESP: begin
        gnt[idx]       = 1'b1;
        rsp_valid[idx] = 1'b1;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      idx     <= '0;
      div_w   <= '0;
      div_d   <= '0;
      tmo_cnt <= '0;
      done_q  <= 1'b0;
      rsp_quo <= '0;
      rsp_rem <= '0;
      rsp_ov  <= 1'b0;
      rsp_dbz <= 1'b0;
      rsp_tmo <= 1'b0;
    end else begin
      done_q <= div_done;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            idx   <= pick_idx;
            div_w <= w_arr[pick_idx];
            div_d <= d_arr[pick_idx];
          end
        end
        S_START: tmo_cnt <= '0;
        S_WAIT: begin
          // Completion takes priority over a timeout landing in the same cycle.
          if (done_rise) begin
            rsp_quo <= div_quo;
            rsp_rem <= div_rem;
            rsp_ov  <= div_ov;
            rsp_dbz <= div_dbz;
            rsp_tmo <= 1'b0;
          end else if (tmo_hit) begin
            rsp_quo <= '0;
            rsp_rem <= '0;
            rsp_ov  <= 1'b0;
            rsp_dbz <= 1'b0;
            rsp_tmo <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RESP: rr_ptr <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
